// File: rtl/ibex_pkg.sv
// FP operator encoding shared between the issue stage and the FPU datapath.
package ibex_pkg;

   typedef enum logic [3:0] {
      FP_ALU_ADD    = 4'd0,
      FP_ALU_SUB    = 4'd1,
      FP_ALU_MUL    = 4'd2,
      FP_ALU_DIV    = 4'd3,
      FP_ALU_SQRT   = 4'd4,
      FP_ALU_FMADD  = 4'd5,
      FP_ALU_MINMAX = 4'd6,
      FP_ALU_SGNJ   = 4'd7,
      FP_ALU_CMP    = 4'd8,
      FP_ALU_CLASS  = 4'd9,
      FP_ALU_CVT    = 4'd10
   } fp_alu_op_e;

endpackage

// File: rtl/fpu_issue_ctrl.sv
// Issue/writeback controller around a combinational FPU, timed as a LATENCY-cycle multicycle path.
// Optional FPU_CTRL_FAST_EN: MINMAX/SGNJ/CMP/CLASS complete after a single EXEC cycle.
module fpu_issue_ctrl #(
   parameter int unsigned LATENCY = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   req_valid_i,
   output logic                   req_ready_o,
   input  ibex_pkg::fp_alu_op_e   req_op_i,
   input  logic [31:0]            req_a_i,
   input  logic [31:0]            req_b_i,
   input  logic [1:0]             req_mode_i,
   input  logic [4:0]             req_rd_i,
   input  logic                   flush_i,
   output ibex_pkg::fp_alu_op_e   fpu_operator_o,
   output logic [31:0]            fpu_operand_a_o,
   output logic [31:0]            fpu_operand_b_o,
   output logic [1:0]             fpu_mode_o,
   input  logic [31:0]            fpu_result_i,
   output logic                   rsp_valid_o,
   input  logic                   rsp_ready_i,
   output logic [31:0]            rsp_result_o,
   output logic [4:0]             rsp_rd_o,
   output logic                   busy_o
);

   import ibex_pkg::*;

   localparam logic [3:0] LatLoad = 4'(LATENCY - 1);

   typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

   state_e      r_state;
   state_e      w_state_next;
   logic [3:0]  r_count;
   logic [3:0]  w_load_cnt;
   fp_alu_op_e  r_op;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [1:0]  r_mode;
   logic [4:0]  r_tag;
   logic [31:0] r_rsp_result;
   logic [4:0]  r_rsp_rd;
   logic        w_req_ready;
   logic        w_accept;
   logic        w_capture;

   assign w_accept  = req_valid_i && w_req_ready;
   // Flush wins over the final EXEC cycle, so a killed op never lands in the response regs.
   assign w_capture = (r_state == StExec) && !flush_i && (r_count == 4'd0);

   always_comb begin
`ifdef FPU_CTRL_FAST_EN
      case (req_op_i)
         FP_ALU_MINMAX, FP_ALU_SGNJ, FP_ALU_CMP, FP_ALU_CLASS: w_load_cnt = 4'd0;
         default:                                              w_load_cnt = LatLoad;
      endcase
`else
      w_load_cnt = LatLoad;
`endif
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle: begin
            if (w_accept) w_state_next = StExec;
         end
         StExec: begin
            if (flush_i)                  w_state_next = StIdle;
            else if (r_count == 4'd0)     w_state_next = StDone;
         end
         StDone: begin
            if (flush_i)                  w_state_next = StIdle;
            else if (rsp_ready_i)         w_state_next = w_accept ? StExec : StIdle;
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_comb begin
      w_req_ready = 1'b0;
      rsp_valid_o = 1'b0;
      busy_o      = 1'b0;
      unique case (r_state)
         StIdle: w_req_ready = !flush_i;
         StExec: busy_o = 1'b1;
         StDone: begin
            busy_o      = 1'b1;
            rsp_valid_o = 1'b1;
            w_req_ready = rsp_ready_i && !flush_i;
         end
         default: ;
      endcase
   end

   // Operand regs only move on acceptance to keep the FPU inputs quiet between ops.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_op         <= FP_ALU_ADD;
         r_a          <= '0;
         r_b          <= '0;
         r_mode       <= '0;
         r_tag        <= '0;
         r_count      <= '0;
         r_rsp_result <= '0;
         r_rsp_rd     <= '0;
      end else begin
         if (w_accept) begin
            r_op    <= req_op_i;
            r_a     <= req_a_i;
            r_b     <= req_b_i;
            r_mode  <= req_mode_i;
            r_tag   <= req_rd_i;
            r_count <= w_load_cnt;
         end else if ((r_state == StExec) && (r_count != 4'd0)) begin
            r_count <= r_count - 4'd1;
         end
         if (w_capture) begin
            r_rsp_result <= fpu_result_i;
            r_rsp_rd     <= r_tag;
         end
      end
   end

   assign req_ready_o     = w_req_ready;
   assign fpu_operator_o  = r_op;
   assign fpu_operand_a_o = r_a;
   assign fpu_operand_b_o = r_b;
   assign fpu_mode_o      = r_mode;
   assign rsp_result_o    = r_rsp_result;
   assign rsp_rd_o        = r_rsp_rd;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: a LATENCY=2 instance for most scenarios and a
// LATENCY=4 instance for the CLASS fast-path timing; both fed by a small FPU stub.
module tb_fpu_issue_ctrl;
   import ibex_pkg::*;

   localparam int unsigned LAT = 2;
`ifdef FPU_CTRL_FAST_EN
   localparam int unsigned ClassLat = 2;
`else
   localparam int unsigned ClassLat = 5;
`endif

   typedef struct packed {
      logic [31:0] res;
      logic [4:0]  rd;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   fp_alu_op_e  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [1:0]  req_mode;
   logic [4:0]  req_rd;
   logic        flush;
   logic        rsp_ready;

   logic        req_ready2, rsp_valid2, busy2;
   fp_alu_op_e  fpu_op2;
   logic [31:0] fpu_a2, fpu_b2, fpu_res2, rsp_result2;
   logic [1:0]  fpu_mode2;
   logic [4:0]  rsp_rd2;

   logic        req_ready4, rsp_valid4, busy4;
   fp_alu_op_e  fpu_op4;
   logic [31:0] fpu_a4, fpu_b4, fpu_res4, rsp_result4;
   logic [1:0]  fpu_mode4;
   logic [4:0]  rsp_rd4;

   int n_checks = 0;
   int n_errors = 0;
   exp_t sb_q[$];
   exp_t sb4_q[$];

   // FPU stand-in: exact IEEE results for the planned vectors, a scrambling hash otherwise.
   function automatic logic [31:0] fpu_model(fp_alu_op_e op, logic [31:0] a, logic [31:0] b);
      if (op == FP_ALU_ADD && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
      if (op == FP_ALU_MUL && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
      if (op == FP_ALU_SUB && a == 32'h40400000 && b == 32'h3F800000) return 32'h40000000;
      if (op == FP_ALU_CLASS) return 32'h00000040;
      return a ^ {b[15:0], b[31:16]} ^ {28'd0, op};
   endfunction

   function automatic exp_t mk(logic [31:0] res, logic [4:0] rd);
      exp_t e;
      e.res = res;
      e.rd  = rd;
      return e;
   endfunction

   assign fpu_res2 = fpu_model(fpu_op2, fpu_a2, fpu_b2);
   assign fpu_res4 = fpu_model(fpu_op4, fpu_a4, fpu_b4);

   fpu_issue_ctrl #(.LATENCY(LAT)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready2),
      .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b), .req_mode_i(req_mode),
      .req_rd_i(req_rd), .flush_i(flush), .fpu_operator_o(fpu_op2), .fpu_operand_a_o(fpu_a2),
      .fpu_operand_b_o(fpu_b2), .fpu_mode_o(fpu_mode2), .fpu_result_i(fpu_res2),
      .rsp_valid_o(rsp_valid2), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result2),
      .rsp_rd_o(rsp_rd2), .busy_o(busy2)
   );

   fpu_issue_ctrl #(.LATENCY(4)) u_dut4 (
      .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready4),
      .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b), .req_mode_i(req_mode),
      .req_rd_i(req_rd), .flush_i(flush), .fpu_operator_o(fpu_op4), .fpu_operand_a_o(fpu_a4),
      .fpu_operand_b_o(fpu_b4), .fpu_mode_o(fpu_mode4), .fpu_result_i(fpu_res4),
      .rsp_valid_o(rsp_valid4), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result4),
      .rsp_rd_o(rsp_rd4), .busy_o(busy4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = 1'b0; req_op = FP_ALU_ADD; req_a = '0; req_b = '0;
      req_mode = '0; req_rd = '0; flush = 1'b0; rsp_ready = 1'b0;
      #3;
      n_checks++; if (rsp_valid2 !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid2); end
      n_checks++; if (busy2 !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b exp 0", busy2); end
      n_checks++; if (rsp_result2 !== 32'h0) begin n_errors++; $display("FAIL reset_result got %h exp 0", rsp_result2); end
      n_checks++; if (rsp_rd2 !== 5'd0) begin n_errors++; $display("FAIL reset_rd got %0d exp 0", rsp_rd2); end
      n_checks++; if ({fpu_op2, fpu_a2, fpu_b2, fpu_mode2} !== '0) begin n_errors++; $display("FAIL reset_fpu_regs got %h/%h/%h exp 0", fpu_op2, fpu_a2, fpu_b2); end
      n_checks++; if (req_ready2 !== 1'b1) begin n_errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready2); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_add_latency();
      exp_t e;
      step();
      req_valid = 1'b1; req_op = FP_ALU_ADD; req_a = 32'h3F800000; req_b = 32'h40000000;
      req_mode = 2'd1; req_rd = 5'd5; rsp_ready = 1'b1;
      #1;
      n_checks++; if (req_ready2 !== 1'b1) begin n_errors++; $display("FAIL add_req_ready got %b exp 1", req_ready2); end
      sb_q.push_back(mk(32'h40400000, 5'd5));
      for (int k = 1; k <= 6; k++) begin
         step();
         req_valid = 1'b0;
         #1;
         n_checks++;
         if (rsp_valid2 !== (k == LAT + 1)) begin
            n_errors++; $display("FAIL add_valid_timing cycle %0d got %b exp %b", k, rsp_valid2, (k == LAT + 1));
         end
         n_checks++;
         if (busy2 !== (k <= LAT + 1)) begin
            n_errors++; $display("FAIL add_busy cycle %0d got %b exp %b", k, busy2, (k <= LAT + 1));
         end
         if (k == 1) begin
            n_checks++;
            if (fpu_a2 !== 32'h3F800000 || fpu_b2 !== 32'h40000000 || fpu_mode2 !== 2'd1) begin
               n_errors++; $display("FAIL add_operands got %h %h %0d exp 3f800000 40000000 1", fpu_a2, fpu_b2, fpu_mode2);
            end
         end
         if (rsp_valid2 && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_checks++; if (rsp_result2 !== e.res) begin n_errors++; $display("FAIL add_result got %h exp %h", rsp_result2, e.res); end
            n_checks++; if (rsp_rd2 !== e.rd) begin n_errors++; $display("FAIL add_rd got %0d exp %0d", rsp_rd2, e.rd); end
         end
      end
   endtask

   task automatic test_mul_stall();
      exp_t e;
      int k;
      step();
      req_valid = 1'b1; req_op = FP_ALU_MUL; req_a = 32'h40000000; req_b = 32'h40400000;
      req_mode = 2'd0; req_rd = 5'd9; rsp_ready = 1'b0;
      #1;
      n_checks++; if (req_ready2 !== 1'b1) begin n_errors++; $display("FAIL mul_req_ready got %b exp 1", req_ready2); end
      sb_q.push_back(mk(32'h40C00000, 5'd9));
      k = 0;
      do begin step(); req_valid = 1'b0; #1; k++; end while (!rsp_valid2 && k < 20);
      n_checks++; if (k != LAT + 1) begin n_errors++; $display("FAIL mul_latency got %0d exp %0d", k, LAT + 1); end
      for (int s = 0; s < 4; s++) begin
         if (s > 0) step();
         req_valid = 1'b1; req_op = FP_ALU_DIV; req_a = 32'hDEADBEEF; req_b = 32'h12345678;
         rsp_ready = 1'b0;
         #1;
         n_checks++; if (rsp_valid2 !== 1'b1) begin n_errors++; $display("FAIL stall_valid cycle %0d got %b exp 1", s, rsp_valid2); end
         n_checks++; if (rsp_result2 !== sb_q[0].res || rsp_rd2 !== sb_q[0].rd) begin n_errors++; $display("FAIL stall_hold got %h/%0d exp %h/%0d", rsp_result2, rsp_rd2, sb_q[0].res, sb_q[0].rd); end
         n_checks++; if (req_ready2 !== 1'b0) begin n_errors++; $display("FAIL stall_req_ready got %b exp 0", req_ready2); end
         n_checks++; if (fpu_a2 !== 32'h40000000) begin n_errors++; $display("FAIL stall_operand got %h exp 40000000", fpu_a2); end
      end
      step();
      req_valid = 1'b0; rsp_ready = 1'b1;
      #1;
      e = sb_q.pop_front();
      n_checks++; if (rsp_valid2 !== 1'b1 || rsp_result2 !== e.res) begin n_errors++; $display("FAIL mul_release got %b/%h exp 1/%h", rsp_valid2, rsp_result2, e.res); end
      step();
      n_checks++; if (rsp_valid2 !== 1'b0 || busy2 !== 1'b0) begin n_errors++; $display("FAIL mul_idle got valid %b busy %b exp 0 0", rsp_valid2, busy2); end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int k;
      step();
      req_valid = 1'b1; req_op = FP_ALU_ADD; req_a = 32'h3F800000; req_b = 32'h40000000;
      req_rd = 5'd3; rsp_ready = 1'b1;
      #1;
      sb_q.push_back(mk(32'h40400000, 5'd3));
      k = 0;
      do begin step(); req_valid = 1'b0; #1; k++; end while (!rsp_valid2 && k < 20);
      n_checks++; if (rsp_valid2 !== 1'b1) begin n_errors++; $display("FAIL b2b_first_timeout got %b exp 1", rsp_valid2); end
      req_valid = 1'b1; req_op = FP_ALU_SUB; req_a = 32'h40400000; req_b = 32'h3F800000;
      req_rd = 5'd7;
      #1;
      n_checks++; if (req_ready2 !== 1'b1) begin n_errors++; $display("FAIL b2b_req_ready got %b exp 1", req_ready2); end
      e = sb_q.pop_front();
      n_checks++; if (rsp_result2 !== e.res || rsp_rd2 !== e.rd) begin n_errors++; $display("FAIL b2b_first got %h/%0d exp %h/%0d", rsp_result2, rsp_rd2, e.res, e.rd); end
      sb_q.push_back(mk(32'h40000000, 5'd7));
      step();
      req_valid = 1'b0;
      #1;
      n_checks++; if (busy2 !== 1'b1 || rsp_valid2 !== 1'b0) begin n_errors++; $display("FAIL b2b_no_idle got busy %b valid %b exp 1 0", busy2, rsp_valid2); end
      n_checks++; if (fpu_op2 !== FP_ALU_SUB) begin n_errors++; $display("FAIL b2b_operator got %0d exp %0d", fpu_op2, FP_ALU_SUB); end
      k = 1;
      while (!rsp_valid2 && k < 20) begin step(); k++; end
      n_checks++; if (k != LAT + 1) begin n_errors++; $display("FAIL b2b_latency got %0d exp %0d", k, LAT + 1); end
      e = sb_q.pop_front();
      n_checks++; if (rsp_result2 !== e.res || rsp_rd2 !== e.rd) begin n_errors++; $display("FAIL b2b_second got %h/%0d exp %h/%0d", rsp_result2, rsp_rd2, e.res, e.rd); end
      step();
   endtask

   task automatic test_flush();
      step();
      req_valid = 1'b1; req_op = FP_ALU_ADD; req_a = 32'h3F800000; req_b = 32'h40000000;
      req_rd = 5'd11; rsp_ready = 1'b1;
      step();
      req_valid = 1'b0;
      #1;
      n_checks++; if (busy2 !== 1'b1) begin n_errors++; $display("FAIL flush_exec got busy %b exp 1", busy2); end
      step();
      flush = 1'b1;
      #1;
      n_checks++; if (req_ready2 !== 1'b0) begin n_errors++; $display("FAIL flush_req_ready got %b exp 0", req_ready2); end
      step();
      flush = 1'b0;
      #1;
      n_checks++; if (busy2 !== 1'b0 || rsp_valid2 !== 1'b0) begin n_errors++; $display("FAIL flush_idle got busy %b valid %b exp 0 0", busy2, rsp_valid2); end
      n_checks++; if (req_ready2 !== 1'b1) begin n_errors++; $display("FAIL flush_ready_after got %b exp 1", req_ready2); end
      n_checks++; if (rsp_result2 !== 32'h40000000 || rsp_rd2 !== 5'd7) begin n_errors++; $display("FAIL flush_no_capture got %h/%0d exp 40000000/7", rsp_result2, rsp_rd2); end
      for (int k = 0; k < 3; k++) begin
         step();
         n_checks++; if (rsp_valid2 !== 1'b0) begin n_errors++; $display("FAIL flush_no_rsp cycle %0d got %b exp 0", k, rsp_valid2); end
      end
   endtask

   task automatic test_reset_in_done();
      int k;
      step();
      req_valid = 1'b1; req_op = FP_ALU_MUL; req_a = 32'h40000000; req_b = 32'h40400000;
      req_mode = 2'd2; req_rd = 5'd9; rsp_ready = 1'b0;
      k = 0;
      do begin step(); req_valid = 1'b0; #1; k++; end while (!rsp_valid2 && k < 20);
      n_checks++; if (rsp_valid2 !== 1'b1) begin n_errors++; $display("FAIL rst_done_timeout got %b exp 1", rsp_valid2); end
      rst_n = 1'b0;
      #1;
      n_checks++; if (rsp_valid2 !== 1'b0 || busy2 !== 1'b0) begin n_errors++; $display("FAIL rst_async_valid got %b busy %b exp 0 0", rsp_valid2, busy2); end
      n_checks++; if (rsp_result2 !== 32'h0 || rsp_rd2 !== 5'd0) begin n_errors++; $display("FAIL rst_async_rsp got %h/%0d exp 0/0", rsp_result2, rsp_rd2); end
      n_checks++; if ({fpu_op2, fpu_a2, fpu_b2, fpu_mode2} !== '0) begin n_errors++; $display("FAIL rst_async_fpu got %h/%h/%h/%0d exp 0", fpu_op2, fpu_a2, fpu_b2, fpu_mode2); end
      step();
      rst_n = 1'b1;
      step();
      n_checks++; if (rsp_valid2 !== 1'b0 || req_ready2 !== 1'b1) begin n_errors++; $display("FAIL rst_after got valid %b ready %b exp 0 1", rsp_valid2, req_ready2); end
   endtask

   task automatic test_class_fast();
      exp_t e;
      step();
      req_valid = 1'b1; req_op = FP_ALU_CLASS; req_a = 32'h3F800000; req_b = 32'h0;
      req_mode = 2'd0; req_rd = 5'd12; rsp_ready = 1'b1;
      #1;
      n_checks++; if (req_ready4 !== 1'b1) begin n_errors++; $display("FAIL class_req_ready got %b exp 1", req_ready4); end
      sb4_q.push_back(mk(32'h00000040, 5'd12));
      for (int k = 1; k <= 8; k++) begin
         step();
         req_valid = 1'b0;
         #1;
         n_checks++;
         if (rsp_valid4 !== (k == ClassLat)) begin
            n_errors++; $display("FAIL class_timing cycle %0d got %b exp %b", k, rsp_valid4, (k == ClassLat));
         end
         if (rsp_valid4 && sb4_q.size() > 0) begin
            e = sb4_q.pop_front();
            n_checks++; if (rsp_result4 !== e.res || rsp_rd4 !== e.rd) begin n_errors++; $display("FAIL class_result got %h/%0d exp %h/%0d", rsp_result4, rsp_rd4, e.res, e.rd); end
         end
      end
   endtask

   task automatic test_random();
      localparam int N = 10;
      int issued = 0;
      int done = 0;
      int cyc = 0;
      exp_t e;
      sb_q.delete();
      req_op = fp_alu_op_e'($urandom_range(0, 10));
      req_a = $urandom(); req_b = $urandom(); req_rd = 5'($urandom_range(0, 31));
      while (done < N && cyc < 400) begin
         step();
         cyc++;
         req_valid = (issued < N);
         rsp_ready = 1'($urandom_range(0, 1));
         #1;
         if (rsp_valid2) begin
            n_checks++;
            if (sb_q.size() == 0) begin
               n_errors++; $display("FAIL rand_unexpected_rsp got %h exp none", rsp_result2);
            end else if (rsp_result2 !== sb_q[0].res || rsp_rd2 !== sb_q[0].rd) begin
               n_errors++; $display("FAIL rand_rsp got %h/%0d exp %h/%0d", rsp_result2, rsp_rd2, sb_q[0].res, sb_q[0].rd);
            end
            if (rsp_ready && sb_q.size() > 0) begin e = sb_q.pop_front(); done++; end
         end
         if (req_valid && req_ready2) begin
            sb_q.push_back(mk(fpu_model(req_op, req_a, req_b), req_rd));
            issued++;
            step();
            req_valid = 1'b0;
            req_op = fp_alu_op_e'($urandom_range(0, 10));
            req_a = $urandom(); req_b = $urandom(); req_rd = 5'($urandom_range(0, 31));
            #1;
            cyc++;
            if (rsp_valid2) begin
               n_checks++; n_errors++; $display("FAIL rand_valid_after_issue got 1 exp 0");
            end
         end
      end
      n_checks++; if (done != N) begin n_errors++; $display("FAIL rand_completed got %0d exp %0d", done, N); end
      req_valid = 1'b0; rsp_ready = 1'b1;
   endtask

   initial begin
      test_reset();
      test_add_latency();
      test_mul_stall();
      test_back_to_back();
      test_flush();
      test_reset_in_done();
      test_class_fast();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Request-side controller that drives the combinational FPU datapath. It accepts one FP operation at a time from the core's decode/issue stage through a valid/ready handshake and registers the operands so the FPU inputs stay stable. It then waits a fixed number of cycles so the FPU's long combinational path can be timed as a multicycle path. Finally it captures the FPU result and returns it, together with the destination-register tag, through a second valid/ready handshake to writeback.

## Interface
- LATENCY, 2: cycles the FPU inputs are held before the result is sampled; legal range 1..15.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- req_valid_i  input  1  issue stage offers an operation.
- req_ready_o  output  1  controller accepts the operation this cycle.
- req_op_i  input  ibex_pkg::fp_alu_op_e  FP operator.
- req_a_i  input  32  operand A.
- req_b_i  input  32  operand B.
- req_mode_i  input  2  conversion mode, passed to the FPU unchanged.
- req_rd_i  input  5  destination register tag.
- flush_i  input  1  kill the in-flight operation.
- fpu_operator_o  output  fp_alu_op_e  registered operator to the FPU.
- fpu_operand_a_o  output  32  registered operand A.
- fpu_operand_b_o  output  32  registered operand B.
- fpu_mode_o  output  2  registered mode.
- fpu_result_i  input  32  FPU combinational result.
- rsp_valid_o  output  1  result is available.
- rsp_ready_i  input  1  writeback consumes the result.
- rsp_result_o  output  32  captured result.
- rsp_rd_o  output  5  tag of the result.
- busy_o  output  1  high whenever the state is not IDLE.

## Operation
- FSM states:
  - IDLE: req_ready_o = !flush_i.
  - EXEC: a 4-bit countdown runs.
  - DONE: rsp_valid_o = 1.
- IDLE → EXEC on req_valid_i && req_ready_o:
  - latch op, a, b, mode into the fpu_* registers and rd into the tag register;
  - load count = LATENCY-1.
- EXEC:
  - if count == 0, capture fpu_result_i into rsp_result_o, drive rsp_rd_o from the tag, and go to DONE;
  - otherwise decrement count.
- DONE:
  - req_ready_o = rsp_ready_i && !flush_i, so a back-to-back issue is possible.
  - On rsp_ready_i with no new request: go to IDLE.
  - On rsp_ready_i with req_valid_i: go directly to EXEC with the new operands latched, and drop rsp_valid_o next cycle.
- flush_i in EXEC or DONE:
  - next state is IDLE and no response is produced;
  - rsp_valid_o deasserts on the next edge;
  - flush_i has priority over every other transition.
- The fpu_* registers load only on request acceptance. In IDLE and DONE they hold the last values, which keeps FPU switching low.
- rsp_result_o and rsp_rd_o hold their values while DONE is stalled, i.e. rsp_valid_o && !rsp_ready_i.
- The controller does not interpret operands. Sign handling for SUB and format selection for CVT belong to the FPU.

## Timing
- Reset values:
  - state IDLE; count 0;
  - rsp_valid_o 0; rsp_result_o 0; rsp_rd_o 0; busy_o 0;
  - all fpu_* outputs all-zero encoding;
  - req_ready_o 1 (if flush_i is low).
- Request handshake in cycle c:
  - EXEC occupies cycles c+1..c+LATENCY;
  - the result is sampled at the end of cycle c+LATENCY;
  - rsp_valid_o is high from cycle c+LATENCY+1.
- Throughput with rsp_ready_i held high: one operation every LATENCY+1 cycles.
- When LATENCY=1, EXEC lasts exactly one cycle.
- Reset asserted mid-operation returns every register to its reset value immediately. No response is emitted for the lost operation.
- rsp_valid_o never drops without rsp_ready_i, except on flush_i or reset.

## Configuration
- FPU_CTRL_FAST_EN defined:
  - FP_ALU_MINMAX, FP_ALU_SGNJ, FP_ALU_CMP and FP_ALU_CLASS load count = 0, so they take 1 EXEC cycle regardless of LATENCY;
  - all other ops use LATENCY.
- FPU_CTRL_FAST_EN undefined: every operator uses LATENCY cycles.

## Test plan
- ADD, LATENCY=2, a=0x3F800000, b=0x40000000, rd=5, rsp_ready_i=1 → rsp_valid_o high exactly 3 cycles after the handshake cycle, with rsp_result_o=0x40400000 and rsp_rd_o=5; busy_o high for 3 cycles.
- MUL, a=0x40000000, b=0x40400000, rsp_ready_i held low 4 cycles → rsp_result_o=0x40C00000 held stable with rsp_valid_o high, and req_ready_o low throughout the stall.
- Back-to-back: in DONE with rsp_ready_i=1, issue SUB of a=0x40400000 and b=0x3F800000 → no IDLE cycle between ops; second response 0x40000000.
- flush_i pulsed in the second EXEC cycle → state is IDLE next cycle, no rsp_valid_o pulse, and req_ready_o=1 the following cycle.
- rst_ni pulled low while in DONE → rsp_valid_o=0, rsp_result_o=0 and fpu_* outputs all zero asynchronously, before the next clock edge.
- CLASS with LATENCY=4 → response 2 cycles after the handshake cycle with FPU_CTRL_FAST_EN defined, and 5 cycles without it.
